imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Boot-time controller that fills the word-addressed instruction memory from a byte stream,
//  then releases the core. Holds the core stalled from reset until a load completes.
//  Sits between an external byte source (UART/debug bridge) and the instruction-memory write port.
// PARAMETERS
//  ADDR_WIDTH  32    width of imem_waddr; word index, zero-extended
//  INST_WIDTH  32    instruction/word width; fixed at 4 bytes
//  IMEM_DEPTH  1024  number of words in instruction memory; maximum legal word count
// PORTS
//  clk          in   1           system clock; single clock domain
//  rst          in   1           synchronous, active-high reset
//  start        in   1           one-cycle pulse: begin a load (honoured in IDLE, DONE, ERR only)
//  s_data       in   8           stream byte
//  s_valid      in   1           s_data valid
//  s_ready      out  1           loader accepts a byte this cycle when s_valid&&s_ready
//  imem_we      out  1           one-cycle write strobe to instruction memory
//  imem_waddr   out  ADDR_WIDTH  word index being written
//  imem_wdata   out  INST_WIDTH  assembled instruction word
//  core_stall   out  1           1 = core PC/fetch frozen
//  load_done    out  1           level: last load finished successfully
//  load_err     out  1           level: last load rejected (length > IMEM_DEPTH)
// BEHAVIOUR
//  Reset: state IDLE; s_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_stall=1,
//   load_done=0, load_err=0; byte lane and word counters cleared.
//  Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N bytes,
//   each word little-endian (first byte -> bits [7:0]).
//  States: IDLE -start-> LEN_LO -byte-> LEN_HI -byte-> {DATA if 1<=N<=IMEM_DEPTH; DONE if N==0;
//   ERR if N>IMEM_DEPTH}. DATA -> DONE the cycle after the write of word N-1.
//   DONE/ERR -start-> LEN_LO (clears load_done/load_err in that transition).
//  s_ready = 1 in LEN_LO, LEN_HI, DATA; 0 in IDLE, DONE, ERR. No backpressure in DATA.
//  Write timing: 4th byte of word k accepted in cycle t -> imem_we=1 in cycle t+1 with
//   imem_waddr=k, imem_wdata=assembled word; imem_we deasserts at t+2 unless another write is due.
//   A byte may be accepted in the same cycle as a write strobe (packer and write reg independent).
//  Word index k runs 0..N-1; never wraps (N<=IMEM_DEPTH enforced at header).
//  core_stall = 1 in every state except DONE; DONE drops it the cycle DONE is entered.
//  ERR: no memory writes, core_stall stays 1, load_err=1 until next start or rst.
//  start while in LEN_LO/LEN_HI/DATA: ignored. s_valid with s_ready=0: byte not consumed.
//  Reset mid-load: return to reset state next edge; partial word discarded; words already
//   written remain in memory; no write strobe issued after rst.
//  Arithmetic: N held in 16 bits; compare against IMEM_DEPTH at ADDR_WIDTH+1 bits.
// STRUCTURE
//  Shared package imem_loader_pkg: state encoding (IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR),
//   LEN_BYTES=2, BYTES_PER_WORD=4 constants.
//  Sub-module imem_word_packer: 2-bit lane counter + shift register; emits word_valid pulse
//   and word on 4th byte; clear input driven by FSM on rst/start.
//  Top holds FSM, word counter, registered write port and status flags.
// TESTING
//  1 Reset: assert rst 2 cycles -> core_stall=1, s_ready=0, imem_we=0, done/err=0.
//  2 Load N=2: start, bytes 02 00 B3 00 31 00 13 01 20 00 -> imem_we at waddr 0 data
//    0x003100B3, then waddr 1 data 0x00200113; then load_done=1, core_stall=0.
//  3 Empty load: start, bytes 00 00 -> DONE after LEN_HI, zero write strobes, core_stall=0.
//  4 Oversize: start, bytes 01 04 (N=1025) -> ERR, load_err=1, no writes, core_stall=1, s_ready=0;
//    then N=1024 load fills to waddr 1023 and completes.
//  5 Gapped stream: random s_valid idles between bytes of N=3 load -> identical writes as gapless;
//    start pulses during DATA ignored.
//  6 Reset mid-word: rst after 2 bytes of word 1 -> no further imem_we; restart loads cleanly
//    from waddr 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared state encoding and stream-format constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    DONE,
    ERR
  } state_t;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian bytes into instruction words; the first byte of a word lands in bits [7:0].
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          clear,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_data,
  output logic                          word_valid,
  output logic [8*BYTES_PER_WORD-1:0]   word
);

  localparam int unsigned LANE_W = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0]                 lane;
  logic [8*(BYTES_PER_WORD-1)-1:0]   shreg;

  always_ff @(posedge clk) begin
    if (clear) begin
      lane  <= '0;
      shreg <= '0;
    end else if (byte_valid) begin
      lane  <= lane + LANE_W'(1);
      shreg <= {byte_data, shreg[8*(BYTES_PER_WORD-1)-1:8]};
    end
  end

  // The final byte bypasses the shift register so the word is ready in its acceptance cycle.
  assign word_valid = byte_valid && (lane == LAST_LANE);
  assign word       = {byte_data, shreg};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes words into instruction memory,
// and holds the core stalled until a load completes successfully.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned IMEM_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [INST_WIDTH-1:0] imem_wdata,
  output logic                  core_stall,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int unsigned HDR_BITS = 8 * LEN_BYTES;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(IMEM_DEPTH);

  state_t                      state;
  logic [HDR_BITS-1:0]         len;
  logic [HDR_BITS-1:0]         word_cnt;
  logic                        done_pending;
  logic                        accept;
  logic                        start_ok;
  logic                        packer_clear;
  logic                        word_valid;
  logic [8*BYTES_PER_WORD-1:0] word;
  logic [HDR_BITS-1:0]         n_next;
  logic [ADDR_WIDTH:0]         n_ext;

  assign accept       = s_valid && s_ready;
  assign start_ok     = start && (state == IDLE || state == DONE || state == ERR);
  assign packer_clear = rst || start_ok;
  assign n_next       = {s_data, len[7:0]};
  assign n_ext        = (ADDR_WIDTH+1)'(n_next);

  imem_word_packer u_packer (
    .clk        (clk),
    .clear      (packer_clear),
    .byte_valid (accept && state == DATA),
    .byte_data  (s_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      s_ready      <= 1'b0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      core_stall   <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      len          <= '0;
      word_cnt     <= '0;
      done_pending <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN_LO;
            s_ready    <= 1'b1;
            core_stall <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= s_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[HDR_BITS-1:8] <= s_data;
            word_cnt          <= '0;
            done_pending      <= 1'b0;
            if (n_next == '0) begin
              state      <= DONE;
              s_ready    <= 1'b0;
              core_stall <= 1'b0;
              load_done  <= 1'b1;
            end else if (n_ext > DEPTH_EXT) begin
              state    <= ERR;
              s_ready  <= 1'b0;
              load_err <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          // done_pending marks the cycle the final write is on the port; DONE follows it.
          if (word_valid && !done_pending) begin
            imem_we    <= 1'b1;
            imem_waddr <= ADDR_WIDTH'(word_cnt);
            imem_wdata <= INST_WIDTH'(word);
            word_cnt   <= word_cnt + HDR_BITS'(1);
            if (word_cnt == len - HDR_BITS'(1)) done_pending <= 1'b1;
          end
          if (done_pending) begin
            state        <= DONE;
            s_ready      <= 1'b0;
            core_stall   <= 1'b0;
            load_done    <= 1'b1;
            done_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
